// File: rtl/pipeline_register_stall_flush.sv
// Elastic DEPTH-stage pipeline register with per-stage valid, backpressure stall and synchronous flush.
// Optional occupancy counter is compiled only when PIPELINE_REGISTER_OCCUPANCY_COUNT_EN is defined.
module pipeline_register_stall_flush #(
  parameter int W     = 4,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] inp_reg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_reg
`ifdef PIPELINE_REGISTER_OCCUPANCY_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [W-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_vin;
  logic [W-1:0]     w_din  [DEPTH];

  // Advance chain: a stage may move when everything downstream moves or it holds a bubble.
  always_comb begin
    logic w_chain;
    w_adv   = '0;
    w_chain = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_chain  = w_chain | ~r_valid[i];
      w_adv[i] = w_chain;
    end
  end

  // Per-stage incoming valid/data: stage 0 from the upstream port, others from the previous stage.
  always_comb begin
    w_vin    = '0;
    w_vin[0] = in_valid;
    for (int i = 0; i < DEPTH; i++) begin
      w_din[i] = '0;
    end
    w_din[0] = inp_reg;
    for (int i = 1; i < DEPTH; i++) begin
      w_vin[i] = r_valid[i-1];
      w_din[i] = r_data[i-1];
    end
  end

  // Stage registers; a bubble moving in leaves the data register untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= w_vin[i];
          if (w_vin[i]) begin
            r_data[i] <= w_din[i];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0] & ~flush;
  assign out_valid = r_valid[DEPTH-1];
  assign out_reg   = r_data[DEPTH-1];

`ifdef PIPELINE_REGISTER_OCCUPANCY_COUNT_EN
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] r_occ;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Item count: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_push && !w_pop) begin
      r_occ <= r_occ + OCC_ONE;
    end else if (!w_push && w_pop) begin
      r_occ <= r_occ - OCC_ONE;
    end
  end

  assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipeline_register_stall_flush.sv
// Self-checking bench for pipeline_register_stall_flush (W=4, DEPTH=3) using a scoreboard queue.
module tb_pipeline_register_stall_flush;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] inp_reg;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_reg;
`ifdef PIPELINE_REGISTER_OCCUPANCY_COUNT_EN
  logic [1:0] occupancy;
`endif

  int n_total = 0;
  int n_bad   = 0;
  logic [3:0] sb_q[$];

  int stream_ov[7] = '{0, 0, 0, 1, 1, 1, 0};
  int bub_ov[7]    = '{0, 0, 0, 1, 0, 1, 0};

  pipeline_register_stall_flush #(.W(4), .DEPTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp_reg   (inp_reg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_reg   (out_reg)
`ifdef PIPELINE_REGISTER_OCCUPANCY_COUNT_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input logic [31:0] exp);
`ifdef PIPELINE_REGISTER_OCCUPANCY_COUNT_EN
    check_val(tag, 32'(occupancy), exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [3:0] v[3];
    v = '{a, b, c};
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      inp_reg  = v[k];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard: pop/compare on an output handshake, push on an input handshake.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          check_val("sb_data", 32'(out_reg), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(inp_reg);
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inp_reg = 4'h0;
    @(negedge clk);
    check_val("rst_ov", 32'(out_valid), 32'd0);
    check_val("rst_or", 32'(out_reg), 32'd0);
    chk_occ("rst_occ", 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_ir", 32'(in_ready), 32'd1);
    tick();

    // streaming
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      inp_reg  = 4'(c + 1);
      @(negedge clk);
      check_val("stream_ov", 32'(out_valid), 32'(stream_ov[c]));
      if (c >= 3 && c <= 5) check_val("stream_or", 32'(out_reg), 32'(c - 2));
      tick();
    end

    // backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      inp_reg  = 4'(10 + k);
      @(negedge clk);
      check_val("bp_in_ready", 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_ir_full", 32'(in_ready), 32'd0);
    check_val("bp_ov_full", 32'(out_valid), 32'd1);
    check_val("bp_or_full", 32'(out_reg), 32'hA);
    chk_occ("bp_occ", 32'd3);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("bp_drain_ov", 32'(out_valid), (k < 3) ? 32'd1 : 32'd0);
      if (k < 3) check_val("bp_drain_or", 32'(out_reg), 32'(10 + k));
      tick();
    end

    // simultaneous push and pop while full
    fill3(4'h1, 4'h2, 4'h3);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inp_reg   = 4'h7;
    @(negedge clk);
    check_val("pp_ir", 32'(in_ready), 32'd1);
    chk_occ("pp_occ_pre", 32'd3);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("pp_or", 32'(out_reg), (k == 0) ? 32'h2 : ((k == 1) ? 32'h3 : 32'h7));
      if (k == 0) chk_occ("pp_occ_post", 32'd3);
      tick();
    end
    @(negedge clk);
    check_val("pp_ov_empty", 32'(out_valid), 32'd0);
    tick();

    // flush
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inp_reg   = 4'h4;
    tick();
    inp_reg   = 4'h5;
    tick();
    flush   = 1'b1;
    inp_reg = 4'h9;
    @(negedge clk);
    check_val("fl_ir", 32'(in_ready), 32'd0);
    check_val("fl_or_pre", 32'(out_reg), 32'h7);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_val("fl_ov", 32'(out_valid), 32'd0);
    check_val("fl_or", 32'(out_reg), 32'd0);
    chk_occ("fl_occ", 32'd0);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("fl_quiet_ov", 32'(out_valid), 32'd0);
      tick();
    end

    // bubbles
    for (int c = 0; c < 7; c++) begin
      in_valid = (c == 0 || c == 2);
      inp_reg  = (c == 0) ? 4'h5 : 4'h6;
      @(negedge clk);
      check_val("bub_ov", 32'(out_valid), 32'(bub_ov[c]));
      if (c == 3 || c == 4) check_val("bub_or5", 32'(out_reg), 32'h5);
      if (c == 5) check_val("bub_or6", 32'(out_reg), 32'h6);
      tick();
    end

    // async reset during a stall
    fill3(4'hB, 4'hC, 4'hD);
    in_valid = 1'b1;
    inp_reg  = 4'hE;
    @(negedge clk);
    check_val("rs_ov_pre", 32'(out_valid), 32'd1);
    check_val("rs_or_pre", 32'(out_reg), 32'hB);
    @(posedge clk); #2;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check_val("rs_ov", 32'(out_valid), 32'd0);
    check_val("rs_or", 32'(out_reg), 32'd0);
    chk_occ("rs_occ", 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("rs_ir", 32'(in_ready), 32'd1);
    check_val("rs_ov_post", 32'(out_valid), 32'd0);
    tick();

    check_val("sb_left", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
